// File: rtl/serial_alu_pkg.sv
// Shared opcodes, sequencer states and opcode legality for the bit-serial ALU sequencer.
// Optional subtract support is enabled by defining SERIAL_ALU_SUB_EN.
package serial_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Opcodes are dense from 000 upward, so legality is a single upper bound.
  function automatic logic op_legal(input logic [2:0] op);
`ifdef SERIAL_ALU_SUB_EN
    return (op <= OP_SUB);
`else
    return (op <= OP_XNOR);
`endif
  endfunction

endpackage

// File: rtl/serial_shreg.sv
// WIDTH-bit parallel-load, right-shift register; ser_in enters at the MSB.
module serial_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_val;
    end else if (shift) begin
      shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q = shreg_q;

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving a 1-bit ALU slice LSB first into a WIDTH-bit result.
// Define SERIAL_ALU_SUB_EN to enable opcode 101 (A - B via ~B plus carry-in 1).
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             Err,
  output logic [2:0]       Slice_Mode,
  output logic             Slice_A,
  output logic             Slice_B,
  output logic             Slice_C_in,
  input  logic             Slice_X,
  input  logic             Slice_C_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [2:0]       mode_q, mode_d;

  logic             ld_ops, ld_res, run;
  logic [WIDTH-1:0] a_q, b_q, res_q, b_load;
  logic             carry_init;
  logic [2:0]       mode_map;

`ifdef SERIAL_ALU_SUB_EN
  logic is_sub;
  assign is_sub     = (Mode == OP_SUB);
  assign b_load     = is_sub ? ~B_in : B_in;
  assign carry_init = is_sub;
  assign mode_map   = is_sub ? OP_ADD : Mode;
`else
  assign b_load     = B_in;
  assign carry_init = 1'b0;
  assign mode_map   = Mode;
`endif

  // Operand registers shift in zeros, so bit 0 reads 0 once the last bit has gone out.
  serial_shreg #(.WIDTH(WIDTH)) u_a_reg (
    .clk(CLK), .rst(RST), .load(ld_ops), .load_val(A_in),
    .shift(run), .ser_in(1'b0), .q(a_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b_reg (
    .clk(CLK), .rst(RST), .load(ld_ops), .load_val(b_load),
    .shift(run), .ser_in(1'b0), .q(b_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_res_reg (
    .clk(CLK), .rst(RST), .load(ld_res), .load_val({WIDTH{1'b0}}),
    .shift(run), .ser_in(Slice_X), .q(res_q)
  );

  // Next-state, datapath control and status update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    err_d       = err_q;
    mode_d      = mode_q;
    ld_ops      = 1'b0;
    ld_res      = 1'b0;
    run         = 1'b0;

    case (state_q)
      RUN: begin
        run     = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        carry_d = Slice_C_out;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          carry_d     = 1'b0;
          carry_out_d = Slice_C_out;
          zero_d      = ({Slice_X, res_q[WIDTH-1:1]} == {WIDTH{1'b0}});
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          carry_out_d = 1'b0;
          if (op_legal(Mode)) begin
            state_d = RUN;
            ld_ops  = 1'b1;
            cnt_d   = '0;
            carry_d = carry_init;
            mode_d  = mode_map;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            ld_res  = 1'b1;
            zero_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b1;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      mode_q      <= OP_ADD;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign Result     = res_q;
  assign Carry      = carry_out_q;
  assign Zero       = zero_q;
  assign Err        = err_q;
  assign Slice_Mode = mode_q;
  assign Slice_A    = a_q[0];
  assign Slice_B    = b_q[0];
  assign Slice_C_in = carry_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomised self-checking bench for serial_alu_seq with a behavioural 1-bit slice attached.
module tb_serial_alu_seq;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic [2:0]   Mode;
  logic [W-1:0] A_in, B_in;
  logic         busy, done, Carry, Zero, Err;
  logic [W-1:0] Result;
  logic [2:0]   Slice_Mode;
  logic         Slice_A, Slice_B, Slice_C_in, Slice_X, Slice_C_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  serial_alu_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .Mode(Mode), .A_in(A_in), .B_in(B_in),
    .busy(busy), .done(done), .Result(Result), .Carry(Carry), .Zero(Zero), .Err(Err),
    .Slice_Mode(Slice_Mode), .Slice_A(Slice_A), .Slice_B(Slice_B), .Slice_C_in(Slice_C_in),
    .Slice_X(Slice_X), .Slice_C_out(Slice_C_out)
  );

  // 1-bit ALU slice: full adder in ADD mode, bitwise ops otherwise with C_out gated to 0.
  always_comb begin
    Slice_X     = 1'b0;
    Slice_C_out = 1'b0;
    case (Slice_Mode)
      3'b000: begin
        Slice_X     = Slice_A ^ Slice_B ^ Slice_C_in;
        Slice_C_out = (Slice_A & Slice_B) | (Slice_C_in & (Slice_A ^ Slice_B));
      end
      3'b001:  Slice_X = Slice_A & Slice_B;
      3'b010:  Slice_X = Slice_A | Slice_B;
      3'b011:  Slice_X = Slice_A ^ Slice_B;
      3'b100:  Slice_X = ~(Slice_A ^ Slice_B);
      default: Slice_X = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result as {err, carry, result}.
  function automatic logic [9:0] ref_op(input logic [2:0] m, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] s;
    ref_op = 10'h200;
    case (m)
      3'd0: begin
        s      = {1'b0, a} + {1'b0, b};
        ref_op = {1'b0, s};
      end
      3'd1: ref_op = {2'b00, a & b};
      3'd2: ref_op = {2'b00, a | b};
      3'd3: ref_op = {2'b00, a ^ b};
      3'd4: ref_op = {2'b00, ~(a ^ b)};
`ifdef SERIAL_ALU_SUB_EN
      3'd5: ref_op = {1'b0, (a >= b), 8'(a - b)};
`endif
      default: ref_op = 10'h200;
    endcase
  endfunction

  // Issue one op at the current cycle; returns in the done cycle (or after the time bound).
  task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                        input bit poke);
    logic [9:0] e;
    logic [7:0] bx;
    int lat;
    e  = ref_op(m, a, b);
    bx = b;
`ifdef SERIAL_ALU_SUB_EN
    if (m == 3'd5) bx = ~b;
`endif
    start = 1'b1; Mode = m; A_in = a; B_in = b;
    @(posedge CLK); #1;
    start = 1'b0;
    lat   = 1;
    check("busy_after_start", 32'(busy), 32'(!e[9]));
    if (!e[9]) check("slice_mode", 32'(Slice_Mode), 32'((m == 3'd5) ? 3'd0 : m));
    while (!done && lat < 40) begin
      if (lat <= int'(W)) begin
        check("slice_a_bit", 32'(Slice_A), 32'(a[lat-1]));
        check("slice_b_bit", 32'(Slice_B), 32'(bx[lat-1]));
      end
      if (poke && lat == 3) begin
        start = 1'b1; Mode = 3'($urandom); A_in = 8'($urandom); B_in = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", 32'(lat), e[9] ? 32'd1 : 32'(W + 1));
    check("result", 32'(Result), 32'(e[7:0]));
    check("carry", 32'(Carry), 32'(e[8]));
    check("zero", 32'(Zero), 32'(e[7:0] == 8'h00));
    check("err", 32'(Err), 32'(e[9]));
    check("busy_in_done", 32'(busy), 32'd0);
    check("slice_idle", 32'({Slice_A, Slice_B, Slice_C_in}), 32'd0);
  endtask

  // One idle cycle after a done: pulse must drop and the result must hold.
  task automatic idle_check(input logic [7:0] res_exp);
    @(posedge CLK); #1;
    check("done_pulse_len", 32'(done), 32'd0);
    check("result_hold", 32'(Result), 32'(res_exp));
  endtask

  initial begin
    logic [2:0] m;
    logic [7:0] a, b;
    logic [9:0] e;
    int seen_done;

    RST = 1'b1; start = 1'b0; Mode = 3'd0; A_in = '0; B_in = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_flags", 32'({Carry, Zero, Err}), 32'b010);
    check("rst_slice", 32'({Slice_Mode, Slice_A, Slice_B, Slice_C_in}), 32'd0);
    RST = 1'b0;

    run_op(3'd0, 8'h5A, 8'h33, 1'b0);
    idle_check(8'h8D);
    run_op(3'd0, 8'hFF, 8'h01, 1'b0);
    run_op(3'd4, 8'hF0, 8'hAA, 1'b0);
    run_op(3'd1, 8'hF0, 8'hAA, 1'b0);
    run_op(3'd2, 8'hF0, 8'hAA, 1'b1);
    idle_check(8'hFA);
    run_op(3'd6, 8'h12, 8'h34, 1'b0);
    idle_check(8'h00);
    run_op(3'd5, 8'h10, 8'h01, 1'b0);
    run_op(3'd5, 8'h01, 8'h02, 1'b0);
    run_op(3'd3, 8'hC3, 8'h5A, 1'b1);

    // Reset while bit 4 is on the slice.
    start = 1'b1; Mode = 3'd0; A_in = 8'hFF; B_in = 8'h01;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(Result), 32'd0);
    check("abort_flags", 32'({Carry, Zero, Err}), 32'b010);
    check("abort_slice", 32'({Slice_Mode, Slice_A, Slice_B, Slice_C_in}), 32'd0);
    seen_done = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (done) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    run_op(3'd0, 8'h01, 8'h01, 1'b0);
    idle_check(8'h02);

    // Reset wins over a simultaneous start.
    RST = 1'b1; start = 1'b1; Mode = 3'd0; A_in = 8'h11; B_in = 8'h22;
    @(posedge CLK); #1;
    RST = 1'b0; start = 1'b0;
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    check("rst_vs_start_idle", 32'(busy | done), 32'd0);

    repeat (40) begin
      m = 3'($urandom_range(7, 0));
      a = 8'($urandom);
      b = 8'($urandom);
      e = ref_op(m, a, b);
      run_op(m, a, b, 1'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) idle_check(e[7:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial sequencer that wraps the 1-bit ALU slice into a WIDTH-bit operation unit. It latches two parallel operands and an opcode on a start handshake. It then feeds the slice one bit per clock, LSB first, closes the carry loop through a flip-flop, and collects the slice's X output back into a parallel result. It sits directly upstream of the slice, driving its Mode/A/B/C_in, and directly downstream of it, consuming X/C_out.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- start  input  1  request; accepted only on a cycle with busy=0
- Mode  input  3  opcode, sampled with start
- A_in  input  WIDTH  operand A, sampled with start
- B_in  input  WIDTH  operand B, sampled with start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; Result/Carry/Zero/Err valid
- Result  output  WIDTH  result; holds until next accepted start
- Carry  output  1  final carry (add/sub), 0 otherwise
- Zero  output  1  Result == 0
- Err  output  1  illegal opcode on the completed request
- Slice_Mode  output  3  to slice Mode
- Slice_A  output  1  to slice A
- Slice_B  output  1  to slice B
- Slice_C_in  output  1  to slice C_in
- Slice_X  input  1  from slice X (combinational)
- Slice_C_out  input  1  from slice C_out (combinational)

## Operation
- Opcodes: 000 ADD, 001 AND, 010 OR, 011 XOR, 100 XNOR; 101 SUB only with the macro; other values illegal.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1, legal opcode: load operand shift registers, latch opcode, load the carry flop (0 for ADD, 1 for SUB, 0 otherwise), clear the bit counter, enter RUN.
- Illegal opcode: no RUN. Go to DONE. Result=0, Carry=0, Zero=1, Err=1.
- RUN, each cycle:
  - Slice_A/Slice_B = bit 0 of the A/B shift registers (B inverted for SUB).
  - Slice_C_in = carry flop.
  - Slice_Mode = latched opcode (000 for SUB).
  - At the clock edge: both operand registers shift right; Slice_X is shifted into the MSB of the result register (shift right); carry flop <= Slice_C_out; counter++.
- RUN exits to DONE when the counter reaches WIDTH-1.
- DONE: done=1, busy=0. Result = result register. Carry = carry flop (non-add modes yield 0 because the slice gates C_out). Next state is IDLE, or RUN if start is accepted.
- Outside RUN: Slice_A/B/C_in are driven 0 and Slice_Mode holds its last value.
- start while busy=1: ignored, not queued.

## Timing
- start sampled at edge t.
- Bit k presented during cycle t+1+k.
- done high during cycle t+WIDTH+1; busy high during cycles t+1 through t+WIDTH.
- Throughput: one op per WIDTH+1 cycles; back-to-back issue via start during DONE.
- Illegal opcode: done in cycle t+1.
- Reset values: busy=0, done=0, Result=0, Carry=0, Zero=1, Err=0, Slice_Mode=000, Slice_A/B/C_in=0, state IDLE.
- RST mid-RUN: abort at the next edge. No done pulse; outputs take their reset values.
- RST and start in the same cycle: RST wins.

## Configuration
- SERIAL_ALU_SUB_EN defined: opcode 101 = A − B, computed as the add of ~B with initial carry 1. Carry=1 means no borrow.
- SERIAL_ALU_SUB_EN undefined: 101 is illegal (Err path); the inversion logic is absent.

## Structure
- Package serial_alu_pkg:
  - opcode constants OP_ADD, OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_SUB
  - state enum (IDLE/RUN/DONE)
  - opcode-legal function
- Sub-module serial_shreg: WIDTH-bit parallel-load, right-shift register with serial input. Instantiated three times: A, B and result.

## Test plan (WIDTH=8)
- ADD 0x5A+0x33 -> Result 0x8D, Carry 0, Zero 0; done exactly 9 cycles after start.
- ADD 0xFF+0x01 -> Result 0x00, Carry 1, Zero 1.
- XNOR 0xF0,0xAA -> 0xA5; AND -> 0xA0; OR -> 0xFA; all with Carry 0.
- Mode 110 -> done next cycle, Err 1, Result 0x00; start pulsed during busy is ignored (single done).
- RST asserted during bit 4 of an ADD -> no done, busy 0 and Result 0x00 next cycle; a following ADD 0x01+0x01 returns 0x02.
- Macro on: SUB 0x10−0x01 -> 0x0F, Carry 1; SUB 0x01−0x02 -> 0xFF, Carry 0. Macro off: mode 101 -> Err 1.
